// File: rtl/floor_request_scheduler_if.sv
// Car-side bus of the floor request scheduler: request inputs, car position
// feedback and the registered target/status outputs.
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 6
) ();
  logic [NUM_FLOORS-1:0] SW;
  logic                  closeDoor;
  logic [NUM_FLOORS-1:0] curFloor;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] whichFloor;
  logic                  targetValid;
  logic                  dirUp;
  logic                  posErr;

  // Car controller / stimulus side
  modport master (
    output SW, closeDoor, curFloor, arrived,
    input  pending, whichFloor, targetValid, dirUp, posErr
  );

  // Scheduler side
  modport slave (
    input  SW, closeDoor, curFloor, arrived,
    output pending, whichFloor, targetValid, dirUp, posErr
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Floor request scheduler: sticky pending-request mask plus a SCAN
// (keep-direction) selector that presents one registered one-hot target
// floor to the car motion controller. All outputs are registered.
module floor_request_scheduler #(
  parameter int NUM_FLOORS     = 6,
  parameter int HOME_FLOOR     = 0,
  parameter bit LATCH_ON_CLOSE = 1'b0
) (
  input logic                       clk,
  input logic                       reset,
  floor_request_scheduler_if.slave  bus
);

  localparam int IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam logic [NUM_FLOORS-1:0] ONE_V  = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [NUM_FLOORS-1:0] HOME_V = ONE_V << HOME_FLOOR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  // Registers
  state_e                state_q;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] which_q;
  logic [NUM_FLOORS-1:0] sw_prev_q;
  logic                  target_valid_q;
  logic                  dir_up_q;
  logic                  pos_err_q;

  // Next-state and decode signals
  state_e                state_d;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] which_d;
  logic [NUM_FLOORS-1:0] cap_s;
  logic [NUM_FLOORS-1:0] clr_s;
  logic [NUM_FLOORS-1:0] above_s;
  logic [NUM_FLOORS-1:0] below_s;
  logic [IW-1:0]         cur_idx_s;
  logic [IW-1:0]         up_idx_s;
  logic [IW-1:0]         dn_idx_s;
  logic [IW-1:0]         dist_up_s;
  logic [IW-1:0]         dist_dn_s;
  logic                  pos_ok_s;

  // Request capture and pending-mask update; a clear beats a same-cycle set
  always_comb begin
    cap_s     = '0;
    clr_s     = '0;
    pending_d = pending_q;
    if (LATCH_ON_CLOSE) begin
      cap_s = bus.closeDoor ? bus.SW : '0;
    end else begin
      cap_s = bus.SW & ~sw_prev_q;
    end
    if (bus.arrived && pos_ok_s) begin
      clr_s = bus.curFloor;
    end else begin
      clr_s = '0;
    end
    pending_d = (pending_q | cap_s) & ~clr_s;
  end

  // Car position decode and above/below split of the registered pending mask
  always_comb begin
    pos_ok_s  = ($countones(bus.curFloor) == 32'd1);
    cur_idx_s = '0;
    above_s   = '0;
    below_s   = '0;
    up_idx_s  = '0;
    dn_idx_s  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bus.curFloor[i]) begin
        cur_idx_s = IW'(i);
      end else begin
        cur_idx_s = cur_idx_s;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_s[i] = pending_q[i] && (i > int'(cur_idx_s));
      below_s[i] = pending_q[i] && (i < int'(cur_idx_s));
    end
    // Highest-to-lowest scan leaves the lowest pending floor above the car
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above_s[i]) begin
        up_idx_s = IW'(i);
      end else begin
        up_idx_s = up_idx_s;
      end
    end
    // Lowest-to-highest scan leaves the highest pending floor below the car
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below_s[i]) begin
        dn_idx_s = IW'(i);
      end else begin
        dn_idx_s = dn_idx_s;
      end
    end
    dist_up_s = up_idx_s - cur_idx_s;
    dist_dn_s = cur_idx_s - dn_idx_s;
  end

  // SCAN next-state and target selection; everything holds on a bad position
  always_comb begin
    state_d = state_q;
    which_d = which_q;
    if (pos_ok_s) begin
      case (state_q)
        ST_IDLE: begin
          if ((above_s != '0) && (below_s != '0)) begin
            state_d = (dist_up_s <= dist_dn_s) ? ST_UP : ST_DOWN;
          end else if (above_s != '0) begin
            state_d = ST_UP;
          end else if (below_s != '0) begin
            state_d = ST_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_UP: begin
          if (above_s != '0) begin
            state_d = ST_UP;
          end else if (below_s != '0) begin
            state_d = ST_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DOWN: begin
          if (below_s != '0) begin
            state_d = ST_DOWN;
          end else if (above_s != '0) begin
            state_d = ST_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      case (state_d)
        ST_UP:   which_d = ONE_V << up_idx_s;
        ST_DOWN: which_d = ONE_V << dn_idx_s;
        default: which_d = which_q;
      endcase
    end else begin
      state_d = state_q;
      which_d = which_q;
    end
  end

  // State register with registered outputs; sync reset discards all requests
  always_ff @(posedge clk) begin
    sw_prev_q <= bus.SW;
    if (reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      which_q        <= HOME_V;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b0;
      pos_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      which_q        <= which_d;
      target_valid_q <= (state_d != ST_IDLE);
      dir_up_q       <= (state_d == ST_UP);
      pos_err_q      <= ~pos_ok_s;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.whichFloor  = which_q;
  assign bus.targetValid = target_valid_q;
  assign bus.dirUp       = dir_up_q;
  assign bus.posErr      = pos_err_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Self-checking bench for floor_request_scheduler: a cycle-by-cycle vector
// table for edge-capture mode plus a hand-written level-capture sequence.
module tb_floor_request_scheduler;

  localparam int NF = 6;

  logic clk;
  logic rst0;
  logic rst1;
  int   pass_cnt;
  int   total_cnt;

  floor_request_scheduler_if #(.NUM_FLOORS(NF)) bus0 ();
  floor_request_scheduler_if #(.NUM_FLOORS(NF)) bus1 ();

  floor_request_scheduler #(
    .NUM_FLOORS(NF), .HOME_FLOOR(0), .LATCH_ON_CLOSE(1'b0)
  ) dut_edge (
    .clk(clk), .reset(rst0), .bus(bus0.slave)
  );

  floor_request_scheduler #(
    .NUM_FLOORS(NF), .HOME_FLOOR(0), .LATCH_ON_CLOSE(1'b1)
  ) dut_lvl (
    .clk(clk), .reset(rst1), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NF-1:0] sw;
    logic [NF-1:0] cur;
    logic          arr;
    logic [NF-1:0] pend;
    logic [NF-1:0] which;
    logic          tv;
    logic          dir;
    logic          err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [NF-1:0] sw,
                              input logic [NF-1:0] cur, input logic arr,
                              input logic [NF-1:0] pend, input logic [NF-1:0] which,
                              input logic tv, input logic dir, input logic err);
    vec_t v;
    v.rst = r; v.sw = sw; v.cur = cur; v.arr = arr;
    v.pend = pend; v.which = which; v.tv = tv; v.dir = dir; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    // Edge-mode vectors: inputs applied at a posedge, outputs checked just after
    //                rst   SW         cur        arr   pend       which      tv    dir   err
    vecs.push_back(mk(1'b1, 6'b001000, 6'b000001, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b001000, 6'b000001, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b001000, 6'b000001, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b001000, 6'b000001, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b000000, 6'b000001, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100000, 6'b000001, 1'b0, 6'b100000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100000, 6'b000001, 1'b0, 6'b100000, 6'b100000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100000, 6'b100000, 1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100000, 6'b100000, 1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b000000, 6'b000100, 1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0));
    // SCAN ordering from floor index 2
    vecs.push_back(mk(1'b0, 6'b110000, 6'b000100, 1'b0, 6'b110000, 6'b100000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b000100, 1'b0, 6'b110010, 6'b010000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b000100, 1'b0, 6'b110010, 6'b010000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b010000, 1'b1, 6'b100010, 6'b100000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b010000, 1'b0, 6'b100010, 6'b100000, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b100000, 1'b1, 6'b000010, 6'b000010, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b100000, 1'b0, 6'b000010, 6'b000010, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b110010, 6'b000010, 1'b1, 6'b000000, 6'b000010, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b000000, 6'b000010, 1'b0, 6'b000000, 6'b000010, 1'b0, 1'b0, 1'b0));
    // Same-cycle clear/set conflict at floor index 3
    vecs.push_back(mk(1'b0, 6'b001001, 6'b001000, 1'b1, 6'b000001, 6'b000010, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b001001, 6'b001000, 1'b0, 6'b000001, 6'b000001, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b000000, 6'b000001, 1'b1, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    // Equidistant requests from IDLE resolve upward
    vecs.push_back(mk(1'b0, 6'b100010, 6'b001000, 1'b0, 6'b100010, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100010, 6'b001000, 1'b0, 6'b100010, 6'b100000, 1'b1, 1'b1, 1'b0));
    // Reset mid-travel, then nearer request below wins from IDLE
    vecs.push_back(mk(1'b1, 6'b000000, 6'b001000, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100100, 6'b001000, 1'b0, 6'b100100, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100100, 6'b001000, 1'b0, 6'b100100, 6'b000100, 1'b1, 1'b0, 1'b0));
    // Invalid position: hold scheduler, suppress clear, keep capturing
    vecs.push_back(mk(1'b0, 6'b100100, 6'b000110, 1'b0, 6'b100100, 6'b000100, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 6'b100101, 6'b000110, 1'b1, 6'b100101, 6'b000100, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 6'b100101, 6'b000000, 1'b0, 6'b100101, 6'b000100, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 6'b100101, 6'b001000, 1'b0, 6'b100101, 6'b000100, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b100101, 6'b001000, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b100101, 6'b001000, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0));

    // Level-capture instance parked in reset while the table runs
    rst1 = 1'b1;
    bus1.SW = '0; bus1.closeDoor = 1'b0; bus1.curFloor = 6'b000001; bus1.arrived = 1'b0;
    bus0.closeDoor = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      rst0          = vecs[k].rst;
      bus0.SW       = vecs[k].sw;
      bus0.curFloor = vecs[k].cur;
      bus0.arrived  = vecs[k].arr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.pending", k),     32'(bus0.pending),     32'(vecs[k].pend));
      check($sformatf("v%0d.whichFloor", k),  32'(bus0.whichFloor),  32'(vecs[k].which));
      check($sformatf("v%0d.targetValid", k), 32'(bus0.targetValid), 32'(vecs[k].tv));
      check($sformatf("v%0d.dirUp", k),       32'(bus0.dirUp),       32'(vecs[k].dir));
      check($sformatf("v%0d.posErr", k),      32'(bus0.posErr),      32'(vecs[k].err));
    end

    // Level-capture mode: switch level only counts while closeDoor is high
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    bus1.SW = 6'b010000;
    bus1.closeDoor = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("lvl.nodoor%0d.pending", c), 32'(bus1.pending), 32'(6'b000000));
      check($sformatf("lvl.nodoor%0d.tv", c), 32'(bus1.targetValid), 32'(1'b0));
    end
    bus1.closeDoor = 1'b1;
    @(posedge clk);
    #1;
    check("lvl.door.pending", 32'(bus1.pending), 32'(6'b010000));
    check("lvl.door.which", 32'(bus1.whichFloor), 32'(6'b000001));
    bus1.closeDoor = 1'b0;
    @(posedge clk);
    #1;
    check("lvl.sticky.pending", 32'(bus1.pending), 32'(6'b010000));
    check("lvl.target.which", 32'(bus1.whichFloor), 32'(6'b010000));
    check("lvl.target.tv", 32'(bus1.targetValid), 32'(1'b1));
    check("lvl.target.dir", 32'(bus1.dirUp), 32'(1'b1));
    bus1.curFloor = 6'b010000;
    bus1.arrived  = 1'b1;
    @(posedge clk);
    #1;
    check("lvl.arrive.pending", 32'(bus1.pending), 32'(6'b000000));
    check("lvl.arrive.tv", 32'(bus1.targetValid), 32'(1'b0));
    bus1.arrived = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
